mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree with valid/ready flow control. It is the successor to the fixed 64:1 single-bit mux: input count and element width are configurable, and the tree is built from 4:1 stages, each with a register. A captured selection moves through the tree as a token, which gives one result per cycle at full throughput and lets the output stall under backpressure. It sits between wide register banks or status vectors and narrow consumers such as debug readout and arbitration result paths.

## Interface
- NUM_IN, 64, number of input elements (2..1024)
- ELEM_WIDTH, 1, bits per element
- SEL_WIDTH, 6, select width; must equal clog2(NUM_IN)
- Derived: STAGES = ceil(SEL_WIDTH/2); inputs are zero-padded to 4^STAGES elements
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- flush  input  1  synchronous clear of all in-flight tokens
- in_data  input  NUM_IN*ELEM_WIDTH  element i is in_data[i*ELEM_WIDTH +: ELEM_WIDTH]
- in_sel  input  SEL_WIDTH  index of the element to forward
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  pipeline can accept this cycle
- out_data  output  ELEM_WIDTH  selected element
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- sel_err  output  1  out-of-range select flag; qualified by out_valid

## Operation
- Stage k (k = 0..STAGES-1) holds a data vector of 4^(STAGES-1-k) elements, the remaining select bits, an err bit, and a valid bit v[k].
- Stage 0 captures the 4:1 reduction of the padded input. Within each group of 4 consecutive elements, it selects using in_sel[1:0].
- Stage k captures the 4:1 reduction of stage k-1, using select bits [2k+1:2k].
- For odd SEL_WIDTH, the top stage uses a 1-bit select, zero-extended.
- Enable chain:
  - en[STAGES-1] = !v[STAGES-1] | out_ready
  - en[k] = !v[k] | en[k+1]
  - in_ready = en[0] & !flush
- On en[k], a stage loads the previous stage's data and valid (stage 0 loads in_valid & in_ready). A stage without enable holds its contents.
- out_data, out_valid and sel_err come directly from the last stage's register. There is no combinational path from in_data to out_data.
- in_sel >= NUM_IN selects padded zeros, so out_data = 0.
- flush: all v[k] clear on the next edge and data registers hold. Flush overrides any acceptance in the same cycle.
- No state machine beyond the per-stage valid bits. Token order is strictly preserved.

## Timing
- Reset (rst_n low, asynchronous): every v[k] = 0 and every data register = 0. Hence out_valid = 0, out_data = 0, sel_err = 0. in_ready = 1 once flush is low.
- Latency: a token accepted at edge N appears on out_valid/out_data after edge N+STAGES-1, i.e. STAGES cycles from the in_valid cycle. For the default configuration this is 3.
- Throughput: 1 token per cycle while out_ready = 1.
- Stall: with out_ready = 0, the pipe fills to STAGES tokens and then in_ready = 0. When out_ready rises, in_ready rises in the same cycle (combinational chain). No bubbles or drops occur.
- Bubbles collapse: an empty stage always accepts, even while downstream is stalled.
- Simultaneous out_ready and a full pipe: shift by one and accept one new token.
- Reset asserted mid-stall: all tokens are lost and outputs go to their reset values immediately.

## Configuration
- MUX_TREE_PIPE_SEL_CHECK_EN defined:
  - Stage 0 computes err = (in_sel >= NUM_IN) and carries it with the token.
  - sel_err equals the last stage's err bit, and out_data = 0 for that token.
- Undefined:
  - No err logic exists, and sel_err is tied to 0.
  - Data behaviour is unchanged: out-of-range still returns zero through the padding.

## Test plan
- Reset, then NUM_IN=64, ELEM_WIDTH=1, in_data = 64'h8000_0000_0000_0001, sel=0 then sel=63 on back-to-back cycles with out_ready=1 -> out_valid on cycles 3 and 4, out_data = 1 and 1. Then sel=1 -> out_data = 0.
- NUM_IN=10, ELEM_WIDTH=8, element i = 8'hA0+i, sel sweeps 0..9 continuously -> out_data sequence A0..A9 with no gaps, first result 2 cycles after the first in_valid.
- out_ready=0 while streaming sel=5,6,7,8 -> 3 tokens are accepted, then in_ready=0. Releasing out_ready gives outputs 5,6,7,8 in order with none lost.
- sel=12 with NUM_IN=10: with the macro -> out_data=0, sel_err=1. Without the macro -> out_data=0, sel_err=0.
- Fill the pipe with 3 tokens, assert flush for 1 cycle together with in_valid -> out_valid=0 next cycle, and the concurrent input is not accepted (in_ready=0).
- Pulse rst_n low mid-stream, asynchronously between clock edges -> out_valid and out_data go to 0 immediately. After release, the first new token has full latency.

Source files
------------

// File: rtl/mux_tree_pipe_if.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe_if
// Bundle of the flow-controlled signals of mux_tree_pipe.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer holds data/select stable
// while valid is high and ready is low. Valid never depends combinationally
// on ready; ready may depend combinationally on the consumer's ready.
//
// Signals:
//   flush      master->slave  synchronous clear of in-flight tokens
//   in_data    master->slave  NUM_IN elements of ELEM_WIDTH bits
//   in_sel     master->slave  index of the element to forward
//   in_valid   master->slave  in_data/in_sel valid
//   in_ready   slave->master  pipeline can accept this cycle
//   out_data   slave->master  selected element
//   out_valid  slave->master  out_data valid
//   out_ready  master->slave  consumer accepts out_data
//   sel_err    slave->master  out-of-range select, qualified by out_valid
// -----------------------------------------------------------------------------
interface mux_tree_pipe_if #(
  parameter int NUM_IN     = 64,
  parameter int ELEM_WIDTH = 1,
  parameter int SEL_WIDTH  = 6
);
  logic                         flush;
  logic [NUM_IN*ELEM_WIDTH-1:0] in_data;
  logic [SEL_WIDTH-1:0]         in_sel;
  logic                         in_valid;
  logic                         in_ready;
  logic [ELEM_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         sel_err;

  // Environment side: drives inputs and consumes results.
  modport master (
    output flush, in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  // Mux tree side.
  modport slave (
    input  flush, in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe
// Pipelined NUM_IN:1 multiplexer tree built from registered 4:1 stages, with
// valid/ready flow control. A captured select travels through the tree with
// its data, giving one result per cycle and stalling cleanly on backpressure.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears valids and data registers)
//   bus    mux_tree_pipe_if.slave: flush, in_data, in_sel, in_valid,
//          in_ready, out_data, out_valid, out_ready, sel_err
//
// Optional feature: define MUX_TREE_PIPE_SEL_CHECK_EN to carry an
// out-of-range flag (in_sel >= NUM_IN) with each token onto sel_err.
// Without it sel_err is tied to 0; out-of-range selects return zero either way
// because the input vector is zero-padded to 4^STAGES elements.
// -----------------------------------------------------------------------------
module mux_tree_pipe #(
  parameter int NUM_IN     = 64,
  parameter int ELEM_WIDTH = 1,
  parameter int SEL_WIDTH  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_tree_pipe_if.slave bus
);

  localparam int STAGES   = (SEL_WIDTH + 1) / 2;
  localparam int PAD_N    = 4 ** STAGES;
  localparam int SELW_PAD = 2 * STAGES;
  localparam int EW       = ELEM_WIDTH;

  // Zero-padded input vector and select; padding makes out-of-range selects
  // return 0 and gives odd select widths a zero top bit.
  logic [PAD_N*EW-1:0]  pad_data;
  logic [SELW_PAD-1:0]  sel_pad;

  always_comb begin
    pad_data = '0;
    pad_data[NUM_IN*EW-1:0] = bus.in_data;
    sel_pad = '0;
    sel_pad[SEL_WIDTH-1:0] = bus.in_sel;
  end

  logic [STAGES-1:0] en;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] v_src;
  logic              accept;

  // Enable chain from the output back to the input: a stage may load when it
  // is empty or when everything downstream of it will move this cycle.
  always_comb begin
    logic chain;
    en    = '0;
    chain = ~v_q[STAGES-1] | bus.out_ready;
    en[STAGES-1] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain = ~v_q[k] | chain;
      en[k] = chain;
    end
  end

  assign bus.in_ready = en[0] & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;
  // Flush freezes all payload registers; only the valid bits are cleared.
  assign load         = en & {STAGES{~bus.flush}};

  always_comb begin
    v_src    = '0;
    v_src[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      if (bus.flush) begin
        v_d[k] = 1'b0;
      end else if (en[k]) begin
        v_d[k] = v_src[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // Stage k keeps 4^(STAGES-1-k) elements plus the select bits still needed
  // by the stages after it.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int CNT = 4 ** (STAGES - 1 - k);

    logic [4*CNT*EW-1:0] src_data;
    logic [1:0]          src_sel;
    logic [CNT*EW-1:0]   data_d;
    logic [CNT*EW-1:0]   data_q;

    if (k == 0) begin : g_src
      assign src_data = pad_data;
      assign src_sel  = sel_pad[1:0];
    end else begin : g_src
      assign src_data = g_stg[k-1].data_q;
      assign src_sel  = g_stg[k-1].g_rest.rest_q[1:0];
    end

    always_comb begin
      data_d = '0;
      for (int g = 0; g < CNT; g++) begin
        data_d[g*EW +: EW] = src_data[(4*g + int'(src_sel))*EW +: EW];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (load[k]) begin
        data_q <= data_d;
      end
    end

    // The last stage consumes its select bits immediately, so it stores none.
    if (k < STAGES - 1) begin : g_rest
      localparam int RW = SELW_PAD - 2 * (k + 1);
      logic [RW-1:0] rest_d;
      logic [RW-1:0] rest_q;

      if (k == 0) begin : g_rsrc
        assign rest_d = sel_pad[SELW_PAD-1:2];
      end else begin : g_rsrc
        assign rest_d = g_stg[k-1].g_rest.rest_q[RW+1:2];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rest_q <= '0;
        end else if (load[k]) begin
          rest_q <= rest_d;
        end
      end
    end
  end

  assign bus.out_data  = g_stg[STAGES-1].data_q;
  assign bus.out_valid = v_q[STAGES-1];

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  logic [STAGES-1:0] err_q;
  logic [STAGES-1:0] err_src;

  always_comb begin
    err_src    = '0;
    err_src[0] = (32'(bus.in_sel) >= 32'(NUM_IN));
    for (int k = 1; k < STAGES; k++) begin
      err_src[k] = err_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          err_q[k] <= err_src[k];
        end
      end
    end
  end

  assign bus.sel_err = err_q[STAGES-1];
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_tree_pipe
// Three instances: A = 64x1 (default), B = 10x8 (2 stages, padded),
// C = 64x8 (3 stages). B and C run a scoreboard that predicts each output
// from "element[sel] if sel < NUM_IN else 0" and in_ready from the number of
// tokens in flight versus pipeline depth.
// -----------------------------------------------------------------------------
module tb_mux_tree_pipe;

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int DEPTH_B = 2;
  localparam int DEPTH_C = 3;

  logic clk;
  logic rst_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] exp_b[$];
  logic [8:0] exp_c[$];

  mux_tree_pipe_if #(.NUM_IN(64), .ELEM_WIDTH(1), .SEL_WIDTH(6)) bus_a ();
  mux_tree_pipe_if #(.NUM_IN(10), .ELEM_WIDTH(8), .SEL_WIDTH(4)) bus_b ();
  mux_tree_pipe_if #(.NUM_IN(64), .ELEM_WIDTH(8), .SEL_WIDTH(6)) bus_c ();

  mux_tree_pipe #(.NUM_IN(64), .ELEM_WIDTH(1), .SEL_WIDTH(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_tree_pipe #(.NUM_IN(10), .ELEM_WIDTH(8), .SEL_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));
  mux_tree_pipe #(.NUM_IN(64), .ELEM_WIDTH(8), .SEL_WIDTH(6)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [8:0] model_b(input logic [79:0] d, input logic [3:0] s);
    int idx;
    idx = int'(s);
    if (idx < 10) return {1'b0, d[idx*8 +: 8]};
    return {CHK, 8'h00};
  endfunction

  function automatic logic [8:0] model_c(input logic [511:0] d, input logic [5:0] s);
    int idx;
    idx = int'(s);
    return {1'b0, d[idx*8 +: 8]};
  endfunction

  // ---------------- scoreboards ----------------
  task automatic monitor_b();
    logic [8:0] e;
    logic       rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_b.delete();
      end else begin
        rdy = !bus_b.flush && (bus_b.out_ready || exp_b.size() < DEPTH_B);
        n_cmp++;
        if (bus_b.in_ready !== rdy) begin
          n_fail++;
          $display("FAIL b_in_ready: got %b expected %b at %0t", bus_b.in_ready, rdy, $time);
        end
        if (bus_b.out_valid === 1'b1 && bus_b.out_ready) begin
          n_cmp++;
          if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL b_spurious: got data %h with no token expected at %0t", bus_b.out_data, $time);
          end else begin
            e = exp_b.pop_front();
            if ({bus_b.sel_err, bus_b.out_data} !== e) begin
              n_fail++;
              $display("FAIL b_data: got err/data %h expected %h at %0t",
                       {bus_b.sel_err, bus_b.out_data}, e, $time);
            end
          end
        end
        if (bus_b.flush) exp_b.delete();
        if (bus_b.in_valid && bus_b.in_ready) exp_b.push_back(model_b(bus_b.in_data, bus_b.in_sel));
      end
    end
  endtask

  task automatic monitor_c();
    logic [8:0] e;
    logic       rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_c.delete();
      end else begin
        rdy = !bus_c.flush && (bus_c.out_ready || exp_c.size() < DEPTH_C);
        n_cmp++;
        if (bus_c.in_ready !== rdy) begin
          n_fail++;
          $display("FAIL c_in_ready: got %b expected %b at %0t", bus_c.in_ready, rdy, $time);
        end
        if (bus_c.out_valid === 1'b1 && bus_c.out_ready) begin
          n_cmp++;
          if (exp_c.size() == 0) begin
            n_fail++;
            $display("FAIL c_spurious: got data %h with no token expected at %0t", bus_c.out_data, $time);
          end else begin
            e = exp_c.pop_front();
            if ({bus_c.sel_err, bus_c.out_data} !== e) begin
              n_fail++;
              $display("FAIL c_data: got err/data %h expected %h at %0t",
                       {bus_c.sel_err, bus_c.out_data}, e, $time);
            end
          end
        end
        if (bus_c.flush) exp_c.delete();
        if (bus_c.in_valid && bus_c.in_ready) exp_c.push_back(model_c(bus_c.in_data, bus_c.in_sel));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.sel_err, bus_a.in_ready, bus_a.out_data} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_a: got %b expected 0010",
               {bus_a.out_valid, bus_a.sel_err, bus_a.in_ready, bus_a.out_data});
    end
    n_cmp++;
    if ({bus_b.out_valid, bus_b.sel_err, bus_b.in_ready, bus_b.out_data} !== 11'b001_0000_0000) begin
      n_fail++;
      $display("FAIL reset_b: got %b expected 00100000000",
               {bus_b.out_valid, bus_b.sel_err, bus_b.in_ready, bus_b.out_data});
    end
    n_cmp++;
    if ({bus_c.out_valid, bus_c.sel_err, bus_c.in_ready, bus_c.out_data} !== 11'b001_0000_0000) begin
      n_fail++;
      $display("FAIL reset_c: got %b expected 00100000000",
               {bus_c.out_valid, bus_c.sel_err, bus_c.in_ready, bus_c.out_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_a();
    logic [63:0] ref_bits;
    int          sel_t[3];
    logic        ev;
    logic        ed;
    sel_t = '{0, 63, 1};
    ref_bits = 64'h8000_0000_0000_0001;
    bus_a.in_data   = ref_bits;
    bus_a.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus_a.in_valid = (c < 3);
      bus_a.in_sel   = (c < 3) ? 6'(sel_t[c]) : 6'd0;
      @(negedge clk);
      ev = (c >= 3 && c <= 5);
      ed = 1'b0;
      if (c >= 3 && c <= 5) ed = ref_bits[sel_t[c-3]];
      n_cmp++;
      if (bus_a.out_valid !== ev) begin
        n_fail++;
        $display("FAIL a_valid c%0d: got %b expected %b", c, bus_a.out_valid, ev);
      end
      if (ev) begin
        n_cmp++;
        if (bus_a.out_data !== ed) begin
          n_fail++;
          $display("FAIL a_data c%0d: got %b expected %b", c, bus_a.out_data, ed);
        end
      end
      n_cmp++;
      if (bus_a.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL a_in_ready c%0d: got %b expected 1", c, bus_a.in_ready);
      end
      @(posedge clk);
      #1;
    end
    bus_a.in_valid = 1'b0;
  endtask

  task automatic test_sweep_b();
    logic ev;
    for (int i = 0; i < 10; i++) bus_b.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    bus_b.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus_b.in_valid = (c < 10);
      bus_b.in_sel   = (c < 10) ? 4'(c) : 4'd0;
      @(negedge clk);
      ev = (c >= 2 && c < 12);
      n_cmp++;
      if (bus_b.out_valid !== ev) begin
        n_fail++;
        $display("FAIL sweep_valid c%0d: got %b expected %b", c, bus_b.out_valid, ev);
      end
      if (ev) begin
        n_cmp++;
        if (bus_b.out_data !== 8'hA0 + 8'(c - 2)) begin
          n_fail++;
          $display("FAIL sweep_data c%0d: got %h expected %h", c, bus_b.out_data, 8'hA0 + 8'(c - 2));
        end
      end
      @(posedge clk);
      #1;
    end
    bus_b.in_valid = 1'b0;
  endtask

  task automatic test_sel_err_b();
    int sel_t[3];
    logic [8:0] exp_t[3];
    sel_t = '{12, 15, 3};
    exp_t = '{{CHK, 8'h00}, {CHK, 8'h00}, {1'b0, 8'hA3}};
    bus_b.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus_b.in_valid = (c < 3);
      bus_b.in_sel   = (c < 3) ? 4'(sel_t[c]) : 4'd0;
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        n_cmp++;
        if ({bus_b.out_valid, bus_b.sel_err, bus_b.out_data} !== {1'b1, exp_t[c-2]}) begin
          n_fail++;
          $display("FAIL sel_err c%0d: got v/err/data %h expected %h", c,
                   {bus_b.out_valid, bus_b.sel_err, bus_b.out_data}, {1'b1, exp_t[c-2]});
        end
      end
      @(posedge clk);
      #1;
    end
    bus_b.in_valid = 1'b0;
  endtask

  task automatic test_stall_c();
    int         sel_t[4];
    int         idx;
    logic [7:0] got[$];
    logic       rdy;
    sel_t = '{5, 6, 7, 8};
    idx = 0;
    for (int i = 0; i < 64; i++) bus_c.in_data[i*8 +: 8] = 8'(i);
    for (int c = 0; c < 14; c++) begin
      bus_c.in_valid  = (idx < 4);
      bus_c.in_sel    = (idx < 4) ? 6'(sel_t[idx]) : 6'd0;
      bus_c.out_ready = (c >= 6);
      @(negedge clk);
      rdy = (c < 3) || (c >= 6);
      n_cmp++;
      if (bus_c.in_ready !== rdy) begin
        n_fail++;
        $display("FAIL stall_ready c%0d: got %b expected %b", c, bus_c.in_ready, rdy);
      end
      if (bus_c.out_valid === 1'b1 && bus_c.out_ready) got.push_back(bus_c.out_data);
      if (bus_c.in_valid && bus_c.in_ready === 1'b1) idx++;
      @(posedge clk);
      #1;
    end
    bus_c.in_valid = 1'b0;
    n_cmp++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL stall_count: got %0d outputs expected 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp++;
      if (got[i] !== 8'(sel_t[i])) begin
        n_fail++;
        $display("FAIL stall_order %0d: got %h expected %h", i, got[i], 8'(sel_t[i]));
      end
    end
  endtask

  task automatic test_flush_c();
    logic ev;
    for (int c = 0; c < 10; c++) begin
      bus_c.flush     = (c == 3);
      bus_c.in_valid  = (c <= 3) || (c == 5);
      bus_c.in_sel    = (c == 5) ? 6'd9 : 6'($urandom_range(0, 63));
      bus_c.out_ready = (c >= 5);
      @(negedge clk);
      if (c == 3) begin
        n_cmp++;
        if (bus_c.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_ready: got %b expected 0", bus_c.in_ready);
        end
      end
      if (c >= 4) begin
        ev = (c == 8);
        n_cmp++;
        if (bus_c.out_valid !== ev) begin
          n_fail++;
          $display("FAIL flush_valid c%0d: got %b expected %b", c, bus_c.out_valid, ev);
        end
        if (ev) begin
          n_cmp++;
          if (bus_c.out_data !== 8'd9) begin
            n_fail++;
            $display("FAIL flush_after c%0d: got %h expected 09", c, bus_c.out_data);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    bus_c.flush    = 1'b0;
    bus_c.in_valid = 1'b0;
  endtask

  task automatic test_random();
    int guard;
    for (int c = 0; c < 400; c++) begin
      for (int w = 0; w < 16; w++) bus_c.in_data[w*32 +: 32] = $urandom();
      bus_b.in_data[31:0]  = $urandom();
      bus_b.in_data[63:32] = $urandom();
      bus_b.in_data[79:64] = 16'($urandom());
      bus_b.in_valid  = ($urandom_range(0, 3) != 0);
      bus_b.in_sel    = 4'($urandom_range(0, 15));
      bus_b.out_ready = ($urandom_range(0, 3) != 0);
      bus_b.flush     = ($urandom_range(0, 31) == 0);
      bus_c.in_valid  = ($urandom_range(0, 3) != 0);
      bus_c.in_sel    = 6'($urandom_range(0, 63));
      bus_c.out_ready = ($urandom_range(0, 3) != 0);
      bus_c.flush     = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      #1;
    end
    bus_b.in_valid = 1'b0; bus_b.flush = 1'b0; bus_b.out_ready = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.flush = 1'b0; bus_c.out_ready = 1'b1;
    guard = 0;
    while ((exp_b.size() != 0 || exp_c.size() != 0) && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    n_cmp++;
    if (exp_b.size() != 0 || exp_c.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d tokens outstanding expected 0/0", exp_b.size(), exp_c.size());
    end
    n_cmp++;
    if ({bus_b.out_valid, bus_c.out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL drain_valid: got %b expected 00", {bus_b.out_valid, bus_c.out_valid});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset_c();
    logic [5:0] s;
    logic [8:0] e;
    logic       ev;
    bus_c.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus_c.in_valid = 1'b1;
      bus_c.in_sel   = 6'($urandom_range(0, 63));
      @(negedge clk);
      if (c == 3) begin
        n_cmp++;
        if (bus_c.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL areset_pre: got out_valid %b expected 1", bus_c.out_valid);
        end
      end
      @(posedge clk);
      #1;
    end
    bus_c.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_c.out_valid, bus_c.sel_err, bus_c.out_data} !== 10'd0) begin
      n_fail++;
      $display("FAIL areset_now: got v/err/data %h expected 000",
               {bus_c.out_valid, bus_c.sel_err, bus_c.out_data});
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s = 6'($urandom_range(0, 63));
    for (int w = 0; w < 16; w++) bus_c.in_data[w*32 +: 32] = $urandom();
    e = model_c(bus_c.in_data, s);
    for (int c = 0; c < 5; c++) begin
      bus_c.in_valid = (c == 0);
      bus_c.in_sel   = s;
      @(negedge clk);
      ev = (c == 3);
      n_cmp++;
      if (bus_c.out_valid !== ev) begin
        n_fail++;
        $display("FAIL areset_lat c%0d: got %b expected %b", c, bus_c.out_valid, ev);
      end
      if (ev) begin
        n_cmp++;
        if ({bus_c.sel_err, bus_c.out_data} !== e) begin
          n_fail++;
          $display("FAIL areset_data: got %h expected %h", {bus_c.sel_err, bus_c.out_data}, e);
        end
      end
      @(posedge clk);
      #1;
    end
    bus_c.in_valid = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus_a.flush = 1'b0; bus_a.in_data = '0; bus_a.in_sel = '0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.flush = 1'b0; bus_b.in_data = '0; bus_b.in_sel = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    bus_c.flush = 1'b0; bus_c.in_data = '0; bus_c.in_sel = '0;
    bus_c.in_valid = 1'b0; bus_c.out_ready = 1'b1;
    fork
      monitor_b();
      monitor_c();
    join_none
    test_reset();
    test_basic_a();
    test_sweep_b();
    test_sel_err_b();
    test_stall_c();
    test_flush_c();
    test_random();
    test_async_reset_c();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
